// File: rtl/lcd_result_writer_pkg.sv
// Shared types, HD44780 command bytes and message ROM for the LCD result writer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LATCH,
        ST_CLEAR,
        ST_CONV_WAIT,
        ST_WRITE_CHARS
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_E,
        PH_HOLD,
        PH_WAIT
    } lcd_phase_e;

    typedef enum logic [1:0] {
        MSG_CHEAT,
        MSG_SLOW,
        MSG_WAIT,
        MSG_TIME
    } msg_sel_e;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;

    localparam logic [8*6-1:0]  MSG_CHEAT_STR = "CHEAT!";
    localparam logic [8*8-1:0]  MSG_SLOW_STR  = "TOO SLOW";
    localparam logic [8*7-1:0]  MSG_WAIT_STR  = "WAIT...";
    localparam logic [8*12-1:0] MSG_TIME_STR  = "TIME 0000 ms";

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = LCD_CMD_FUNCSET;
            2'd1:    init_cmd = LCD_CMD_DISPON;
            2'd2:    init_cmd = LCD_CMD_ENTRY;
            default: init_cmd = LCD_CMD_CLEAR;
        endcase
    endfunction

    function automatic logic [3:0] msg_len(input msg_sel_e sel);
        case (sel)
            MSG_CHEAT: msg_len = 4'd6;
            MSG_SLOW:  msg_len = 4'd8;
            MSG_WAIT:  msg_len = 4'd7;
            default:   msg_len = 4'd12;
        endcase
    endfunction

    // Byte idx of the fixed ROM text, counted from the leftmost character.
    function automatic logic [7:0] rom_char(input msg_sel_e sel, input logic [3:0] idx);
        logic [95:0] str_v;
        int          len_v;
        case (sel)
            MSG_CHEAT: begin str_v = {48'h0, MSG_CHEAT_STR}; len_v = 6;  end
            MSG_SLOW:  begin str_v = {32'h0, MSG_SLOW_STR};  len_v = 8;  end
            MSG_WAIT:  begin str_v = {40'h0, MSG_WAIT_STR};  len_v = 7;  end
            default:   begin str_v = MSG_TIME_STR;           len_v = 12; end
        endcase
        if (int'(idx) < len_v) begin
            str_v    = str_v >> (8 * (len_v - 1 - int'(idx)));
            rom_char = str_v[7:0];
        end else begin
            rom_char = 8'h20;
        end
    endfunction

endpackage

// File: rtl/lcd_result_writer_if.sv
// Timer-side request/status signals and the HD44780 write bus of the result writer.
interface lcd_result_writer_if;
    logic       LCDUpdate;
    logic       Cheat;
    logic       Slow;
    logic       Wait;
    logic [9:0] ReactionTime;
    logic       LCDAck;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic [7:0] LCD_DATA;

    modport master (
        input  LCDUpdate, Cheat, Slow, Wait, ReactionTime,
        output LCDAck, LCD_RS, LCD_RW, LCD_E, LCD_DATA
    );

    modport slave (
        output LCDUpdate, Cheat, Slow, Wait, ReactionTime,
        input  LCDAck, LCD_RS, LCD_RW, LCD_E, LCD_DATA
    );
endinterface

// File: rtl/lcd_result_writer_bin2bcd10.sv
// Iterative 10-bit binary to 4-digit BCD (double dabble), one bit per clock.
module bin2bcd10 (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic        done,
    output logic [15:0] bcd
);
    logic [9:0]  bin_r;
    logic [15:0] bcd_r;
    logic [3:0]  cnt_r;
    logic        done_r;
    logic [15:0] adj_s;

    // Add-3 correction of every BCD nibble that is 5 or more before the shift.
    always_comb begin
        adj_s = bcd_r;
        for (int i = 0; i < 4; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
    end

    // Shift sequencer; the result stays put once cnt_r reaches zero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bin_r  <= 10'd0;
            bcd_r  <= 16'd0;
            cnt_r  <= 4'd0;
            done_r <= 1'b0;
        end else if (start) begin
            bin_r  <= bin;
            bcd_r  <= 16'd0;
            cnt_r  <= 4'd10;
            done_r <= 1'b0;
        end else if (cnt_r != 4'd0) begin
            bcd_r  <= {adj_s[14:0], bin_r[9]};
            bin_r  <= {bin_r[8:0], 1'b0};
            cnt_r  <= cnt_r - 4'd1;
            done_r <= (cnt_r == 4'd1);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done = done_r;
    assign bcd  = bcd_r;
endmodule

// File: rtl/lcd_result_writer.sv
// HD44780 8-bit write-only driver: power-on init, then one status message per LCDUpdate.
// Build option LCD_ZERO_BLANK_EN: leading zero digits of the reaction time shown as spaces.
module lcd_result_writer
    import lcd_pkg::*;
#(
    parameter int E_PULSE_CYCLES    = 12,
    parameter int CMD_WAIT_CYCLES   = 50,
    parameter int CLEAR_WAIT_CYCLES = 2000
) (
    input  logic                Clk,
    input  logic                Rst,
    lcd_result_writer_if.master bus
);
    localparam int MAX_A  = (E_PULSE_CYCLES > CMD_WAIT_CYCLES) ? E_PULSE_CYCLES : CMD_WAIT_CYCLES;
    localparam int MAX_C  = (MAX_A > CLEAR_WAIT_CYCLES) ? MAX_A : CLEAR_WAIT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    lcd_state_e  state_r;
    lcd_phase_e  phase_r;
    msg_sel_e    msg_r;
    logic [CW-1:0] cnt_r;
    logic [3:0]  idx_r;
    logic        ack_r, rs_r, e_r, pending_r, bcd_ready_r;
    logic [7:0]  data_r;

    logic        bcd_done_s;
    logic [15:0] bcd_s;
    logic [31:0] dig_s;
    logic [3:0]  next_idx_s;
    logic [7:0]  next_byte_s, first_char_s;
    logic        last_byte_s, bcd_start_s;

    function automatic logic [7:0] msg_byte(input msg_sel_e sel, input logic [3:0] idx,
                                            input logic [31:0] dig);
        logic [31:0] d_v;
        if (sel == MSG_TIME && idx >= 4'd5 && idx <= 4'd8) begin
            d_v      = dig >> (8 * (8 - int'(idx)));
            msg_byte = d_v[7:0];
        end else begin
            msg_byte = rom_char(sel, idx);
        end
    endfunction

    assign bcd_start_s = (state_r == ST_LATCH);

    bin2bcd10 u_bcd (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (bcd_start_s),
        .bin   (bus.ReactionTime),
        .done  (bcd_done_s),
        .bcd   (bcd_s)
    );

    // ASCII digits, thousands in the top byte.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dig_s[8*i +: 8] = {4'h3, bcd_s[4*i +: 4]};
        end
`ifdef LCD_ZERO_BLANK_EN
        if (bcd_s[15:12] == 4'd0) begin
            dig_s[31:24] = 8'h20;
        end else begin
            dig_s[31:24] = {4'h3, bcd_s[15:12]};
        end
        if (bcd_s[15:8] == 8'd0) begin
            dig_s[23:16] = 8'h20;
        end else begin
            dig_s[23:16] = {4'h3, bcd_s[11:8]};
        end
        if (bcd_s[15:4] == 12'd0) begin
            dig_s[15:8] = 8'h20;
        end else begin
            dig_s[15:8] = {4'h3, bcd_s[7:4]};
        end
`else
        dig_s[31:8] = {4'h3, bcd_s[15:12], 4'h3, bcd_s[11:8], 4'h3, bcd_s[7:4]};
`endif
    end

    // Byte sequencing helpers for INIT and WRITE_CHARS.
    always_comb begin
        next_idx_s   = idx_r + 4'd1;
        first_char_s = msg_byte(msg_r, 4'd0, dig_s);
        if (state_r == ST_INIT) begin
            next_byte_s = init_cmd(next_idx_s[1:0]);
            last_byte_s = (idx_r == 4'd3);
        end else begin
            next_byte_s = msg_byte(msg_r, next_idx_s, dig_s);
            last_byte_s = (idx_r == msg_len(msg_r) - 4'd1);
        end
    end

    // Main FSM; the write engine (setup/E/hold/wait) runs inside INIT, CLEAR and WRITE_CHARS.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r     <= ST_INIT;
            phase_r     <= PH_WAIT;
            cnt_r       <= '0;
            idx_r       <= 4'hF;
            msg_r       <= MSG_TIME;
            ack_r       <= 1'b1;
            rs_r        <= 1'b0;
            e_r         <= 1'b0;
            data_r      <= 8'h00;
            pending_r   <= 1'b0;
            bcd_ready_r <= 1'b0;
        end else begin
            pending_r <= pending_r | (bus.LCDUpdate & (state_r != ST_IDLE));
            if (bcd_done_s) bcd_ready_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (bus.LCDUpdate) begin
                        state_r <= ST_LATCH;
                        ack_r   <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (bus.Cheat)     msg_r <= MSG_CHEAT;
                    else if (bus.Slow) msg_r <= MSG_SLOW;
                    else if (bus.Wait) msg_r <= MSG_WAIT;
                    else               msg_r <= MSG_TIME;
                    state_r     <= ST_CLEAR;
                    rs_r        <= 1'b0;
                    data_r      <= LCD_CMD_CLEAR;
                    phase_r     <= PH_SETUP;
                    bcd_ready_r <= 1'b0;
                end
                ST_CONV_WAIT: begin
                    if (bcd_ready_r) begin
                        state_r <= ST_WRITE_CHARS;
                        idx_r   <= 4'd0;
                        rs_r    <= 1'b1;
                        data_r  <= first_char_s;
                        phase_r <= PH_SETUP;
                    end
                end
                ST_INIT, ST_CLEAR, ST_WRITE_CHARS: begin
                    case (phase_r)
                        PH_SETUP: begin
                            e_r     <= 1'b1;
                            cnt_r   <= CW'(E_PULSE_CYCLES - 1);
                            phase_r <= PH_E;
                        end
                        PH_E: begin
                            if (cnt_r == '0) begin
                                e_r     <= 1'b0;
                                phase_r <= PH_HOLD;
                            end else begin
                                cnt_r <= cnt_r - CW'(1);
                            end
                        end
                        PH_HOLD: begin
                            phase_r <= PH_WAIT;
                            if (!rs_r && data_r == LCD_CMD_CLEAR) cnt_r <= CW'(CLEAR_WAIT_CYCLES - 1);
                            else                                  cnt_r <= CW'(CMD_WAIT_CYCLES - 1);
                        end
                        default: begin
                            if (cnt_r != '0) begin
                                cnt_r <= cnt_r - CW'(1);
                            end else if (state_r == ST_CLEAR) begin
                                if (bcd_ready_r) begin
                                    state_r <= ST_WRITE_CHARS;
                                    idx_r   <= 4'd0;
                                    rs_r    <= 1'b1;
                                    data_r  <= first_char_s;
                                    phase_r <= PH_SETUP;
                                end else begin
                                    state_r <= ST_CONV_WAIT;
                                end
                            end else if (last_byte_s) begin
                                // A request arriving as busy ends is serviced straight away.
                                pending_r <= 1'b0;
                                if (pending_r || bus.LCDUpdate) begin
                                    state_r <= ST_LATCH;
                                end else begin
                                    state_r <= ST_IDLE;
                                    ack_r   <= 1'b0;
                                end
                            end else begin
                                idx_r   <= next_idx_s;
                                data_r  <= next_byte_s;
                                phase_r <= PH_SETUP;
                            end
                        end
                    endcase
                end
                default: state_r <= ST_INIT;
            endcase
        end
    end

    assign bus.LCDAck   = ack_r;
    assign bus.LCD_RS   = rs_r;
    assign bus.LCD_RW   = 1'b0;
    assign bus.LCD_E    = e_r;
    assign bus.LCD_DATA = data_r;
endmodule

// File: tb/tb_lcd_result_writer.sv
// Directed, table-driven bench for lcd_result_writer with a bus monitor on LCD_E strobes.
module tb_lcd_result_writer;
    localparam int EP = 3;
    localparam int CWT = 5;
    localparam int CLW = 20;
    localparam int W_CHAR = 1 + EP + 1 + CWT;
    localparam int W_CLR  = 1 + EP + 1 + CLW;

    typedef struct {
        logic [9:0]  rt;
        logic        cheat;
        logic        slow;
        logic        wt;
        logic [95:0] txt;
        int          len;
    } vec_t;

    logic Clk, Rst;
    int   cyc, vectors, miscompares, last_fall;
    logic [8:0] bytes_q[$];
    vec_t vecs[8];

    lcd_result_writer_if bus();

    lcd_result_writer #(.E_PULSE_CYCLES(EP), .CMD_WAIT_CYCLES(CWT), .CLEAR_WAIT_CYCLES(CLW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge Clk) cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strobe monitor: records {RS,DATA} at each E rise, checks pulse width and bus stability.
    initial begin
        logic       e_prev, stable, rst_seen;
        logic [8:0] cur;
        int         plen;
        e_prev = 1'b0; stable = 1'b1; rst_seen = 1'b0; cur = 9'h0; plen = 0;
        forever begin
            @(negedge Clk);
            if (Rst) rst_seen = 1'b1;
            if (bus.LCD_E && !e_prev) begin
                cur = {bus.LCD_RS, bus.LCD_DATA};
                bytes_q.push_back(cur);
                plen = 1; stable = 1'b1; rst_seen = Rst;
            end else if (bus.LCD_E && e_prev) begin
                plen++;
                if ({bus.LCD_RS, bus.LCD_DATA} != cur) stable = 1'b0;
            end else if (!bus.LCD_E && e_prev) begin
                last_fall = cyc;
                if (!rst_seen) begin
                    if ({bus.LCD_RS, bus.LCD_DATA} != cur) stable = 1'b0;
                    chk("e_pulse_len", plen, EP);
                    chk("bus_stable_under_e", {31'd0, stable}, 32'd1);
                end
            end
            e_prev = bus.LCD_E;
        end
    end

    task automatic wait_ack_low(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (bus.LCDAck === 1'b0) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: LCDAck still high after %0d cycles", budget);
        end
    endtask

    task automatic pulse_update(output int p);
        @(negedge Clk);
        bus.LCDUpdate = 1'b1;
        p = cyc;
        @(negedge Clk);
        bus.LCDUpdate = 1'b0;
    endtask

    function automatic logic [7:0] txt_byte(input logic [95:0] txt, input int len, input int i);
        logic [95:0] v;
        v = txt >> (8 * (len - 1 - i));
        return v[7:0];
    endfunction

    task automatic chk_msg(input string name, input int base, input logic [95:0] txt, input int len);
        chk({name, "_clear"}, {23'd0, bytes_q[base]}, {23'd0, 9'h001});
        for (int i = 0; i < len; i++) begin
            chk({name, "_char"}, {23'd0, bytes_q[base+1+i]}, {23'd0, 1'b1, txt_byte(txt, len, i)});
        end
    endtask

    task automatic chk_init(input string name);
        logic [7:0] cmds[4];
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
        chk({name, "_count"}, bytes_q.size(), 4);
        for (int i = 0; i < 4 && i < bytes_q.size(); i++) begin
            chk({name, "_cmd"}, {23'd0, bytes_q[i]}, {24'd0, cmds[i]});
        end
    endtask

    initial begin
        int p, t;
        logic [95:0] t0237, t1023, t0000, t0042, t0100;
        vectors = 0; miscompares = 0; last_fall = 0;
`ifdef LCD_ZERO_BLANK_EN
        t0237 = "TIME  237 ms"; t1023 = "TIME 1023 ms"; t0000 = "TIME    0 ms";
        t0042 = "TIME   42 ms"; t0100 = "TIME  100 ms";
`else
        t0237 = "TIME 0237 ms"; t1023 = "TIME 1023 ms"; t0000 = "TIME 0000 ms";
        t0042 = "TIME 0042 ms"; t0100 = "TIME 0100 ms";
`endif
        vecs[0] = '{10'd237,  1'b0, 1'b0, 1'b0, t0237, 12};
        vecs[1] = '{10'd5,    1'b1, 1'b1, 1'b0, 96'("CHEAT!"), 6};
        vecs[2] = '{10'd500,  1'b0, 1'b1, 1'b1, 96'("TOO SLOW"), 8};
        vecs[3] = '{10'd77,   1'b0, 1'b0, 1'b1, 96'("WAIT..."), 7};
        vecs[4] = '{10'd0,    1'b0, 1'b0, 1'b0, t0000, 12};
        vecs[5] = '{10'd1023, 1'b0, 1'b0, 1'b0, t1023, 12};
        vecs[6] = '{10'd42,   1'b0, 1'b0, 1'b0, t0042, 12};
        vecs[7] = '{10'd100,  1'b0, 1'b0, 1'b0, t0100, 12};

        bus.LCDUpdate = 1'b0; bus.Cheat = 1'b0; bus.Slow = 1'b0; bus.Wait = 1'b0;
        bus.ReactionTime = 10'd0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_ack", {31'd0, bus.LCDAck}, 32'd1);
        chk("rst_e",   {31'd0, bus.LCD_E},  32'd0);
        chk("rst_rs",  {31'd0, bus.LCD_RS}, 32'd0);
        chk("rst_rw",  {31'd0, bus.LCD_RW}, 32'd0);
        chk("rst_data", {24'd0, bus.LCD_DATA}, 32'd0);
        Rst = 1'b0;
        wait_ack_low(400, t);
        chk_init("init");
        chk("init_ack_after_clear_wait", t - last_fall, 1 + CLW);

        // Table-driven messages.
        for (int v = 0; v < 8; v++) begin
            bytes_q.delete();
            bus.Cheat = vecs[v].cheat; bus.Slow = vecs[v].slow; bus.Wait = vecs[v].wt;
            bus.ReactionTime = vecs[v].rt;
            pulse_update(p);
            chk("ack_rise", {31'd0, bus.LCDAck}, 32'd1);
            wait_ack_low(600, t);
            chk("latency", t - p, 2 + W_CLR + vecs[v].len * W_CHAR);
            chk("ack_after_char_wait", t - last_fall, 1 + CWT);
            chk("byte_count", bytes_q.size(), vecs[v].len + 1);
            if (bytes_q.size() == vecs[v].len + 1) chk_msg("msg", 0, vecs[v].txt, vecs[v].len);
            repeat (3) @(negedge Clk);
        end

        // Pulses during the third char: one merged follow-up message with the new value.
        bytes_q.delete();
        bus.Cheat = 1'b0; bus.Slow = 1'b0; bus.Wait = 1'b0; bus.ReactionTime = 10'd237;
        pulse_update(p);
        for (int i = 0; i < 600 && bytes_q.size() < 4; i++) @(negedge Clk);
        chk("pend_reached_char3", bytes_q.size(), 4);
        bus.ReactionTime = 10'd1023;
        pulse_update(p);
        repeat (2) @(negedge Clk);
        pulse_update(p);
        wait_ack_low(1000, t);
        chk("pend_byte_count", bytes_q.size(), 26);
        if (bytes_q.size() == 26) begin
            chk_msg("pend_first", 0, t0237, 12);
            chk_msg("pend_second", 13, t1023, 12);
        end
        repeat (200) @(negedge Clk);
        chk("pend_no_third_msg", bytes_q.size(), 26);
        chk("pend_idle_ack", {31'd0, bus.LCDAck}, 32'd0);

        // Reset while E is high on a char write.
        bytes_q.delete();
        bus.ReactionTime = 10'd42;
        pulse_update(p);
        for (int i = 0; i < 600 && !(bytes_q.size() == 3 && bus.LCD_E); i++) @(negedge Clk);
        chk("mid_e_high", {31'd0, bus.LCD_E}, 32'd1);
        Rst = 1'b1;
        @(negedge Clk);
        chk("mid_rst_e", {31'd0, bus.LCD_E}, 32'd0);
        chk("mid_rst_ack", {31'd0, bus.LCDAck}, 32'd1);
        chk("mid_rst_data", {24'd0, bus.LCD_DATA}, 32'd0);
        chk("mid_rst_rs", {31'd0, bus.LCD_RS}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        bytes_q.delete();
        wait_ack_low(400, t);
        chk_init("reinit");
        repeat (50) @(negedge Clk);
        chk("reinit_no_stale_msg", bytes_q.size(), 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
